// File: rtl/streammult_sched.sv
// streammult_sched: arbitrates whole packets from two requesters onto one AXI-Stream
// multiplier and steers results back by grant order. Optional macro: STREAMMULT_SCHED_CNT_EN.
module streammult_sched #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_ID_FIFO_DEPTH    = 4
) (
  input  logic                          axis_aclk,
  input  logic                          axis_areset,
`ifdef STREAMMULT_SCHED_CNT_EN
  output logic [31:0]                   pkt_cnt0,
  output logic [31:0]                   pkt_cnt1,
`endif
  input  logic                          s00_axis_tvalid,
  output logic                          s00_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                          s00_axis_tlast,
  input  logic                          s01_axis_tvalid,
  output logic                          s01_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s01_axis_tdata,
  input  logic                          s01_axis_tlast,
  output logic                          m00_axis_tvalid,
  input  logic                          m00_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic                          m00_axis_tlast,
  input  logic                          s02_axis_tvalid,
  output logic                          s02_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s02_axis_tdata,
  input  logic                          s02_axis_tlast,
  output logic                          m01_axis_tvalid,
  input  logic                          m01_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m01_axis_tdata,
  output logic                          m01_axis_tlast,
  output logic                          m02_axis_tvalid,
  input  logic                          m02_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m02_axis_tdata,
  output logic                          m02_axis_tlast
);

  localparam int AW = (C_ID_FIFO_DEPTH > 1) ? $clog2(C_ID_FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = C_ID_FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t                     state;
  logic                       last_grant;
  logic [C_ID_FIFO_DEPTH-1:0] id_mem;
  logic [AW-1:0]              wr_ptr;
  logic [AW-1:0]              rd_ptr;
  logic [AW:0]                count;

  logic fifo_full;
  logic fifo_empty;
  logic head_id;
  logic push;
  logic push_id;
  logic pop;
  logic req_last_fire;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign head_id    = id_mem[rd_ptr];

  // Round robin on a tie: the requester that did not win last time goes next.
  assign push    = (state == IDLE) && !fifo_full && (s00_axis_tvalid || s01_axis_tvalid);
  assign push_id = (s00_axis_tvalid && s01_axis_tvalid) ? ~last_grant : s01_axis_tvalid;

  assign req_last_fire = m00_axis_tvalid && m00_axis_tready && m00_axis_tlast;
  assign pop           = s02_axis_tvalid && s02_axis_tready && s02_axis_tlast;

  always_comb begin
    m00_axis_tvalid = 1'b0;
    m00_axis_tdata  = s00_axis_tdata;
    m00_axis_tlast  = s00_axis_tlast;
    s00_axis_tready = 1'b0;
    s01_axis_tready = 1'b0;
    case (state)
      GRANT0: begin
        m00_axis_tvalid = s00_axis_tvalid;
        s00_axis_tready = m00_axis_tready;
      end
      GRANT1: begin
        m00_axis_tvalid = s01_axis_tvalid;
        m00_axis_tdata  = s01_axis_tdata;
        m00_axis_tlast  = s01_axis_tlast;
        s01_axis_tready = m00_axis_tready;
      end
      default: ;
    endcase
  end

  always_comb begin
    m01_axis_tdata  = s02_axis_tdata;
    m01_axis_tlast  = s02_axis_tlast;
    m02_axis_tdata  = s02_axis_tdata;
    m02_axis_tlast  = s02_axis_tlast;
    m01_axis_tvalid = !fifo_empty && !head_id && s02_axis_tvalid;
    m02_axis_tvalid = !fifo_empty &&  head_id && s02_axis_tvalid;
    s02_axis_tready = !fifo_empty && (head_id ? m02_axis_tready : m01_axis_tready);
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: if (push) state <= push_id ? GRANT1 : GRANT0;
        GRANT0: if (req_last_fire) begin
          state      <= IDLE;
          last_grant <= 1'b0;
        end
        GRANT1: if (req_last_fire) begin
          state      <= IDLE;
          last_grant <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      id_mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        id_mem[wr_ptr] <= push_id;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef STREAMMULT_SCHED_CNT_EN
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (m01_axis_tvalid && m01_axis_tready && m01_axis_tlast) pkt_cnt0 <= pkt_cnt0 + 1'b1;
      if (m02_axis_tvalid && m02_axis_tready && m02_axis_tlast) pkt_cnt1 <= pkt_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_streammult_sched.sv
// Self-checking bench for streammult_sched with a queued behavioural 16x16 signed multiplier.
module tb_streammult_sched;
  localparam int W   = 32;
  localparam int TMO = 200;

  logic         axis_aclk;
  logic         axis_areset;
  logic         s00_axis_tvalid, s00_axis_tready, s00_axis_tlast;
  logic [W-1:0] s00_axis_tdata;
  logic         s01_axis_tvalid, s01_axis_tready, s01_axis_tlast;
  logic [W-1:0] s01_axis_tdata;
  logic         m00_axis_tvalid, m00_axis_tready, m00_axis_tlast;
  logic [W-1:0] m00_axis_tdata;
  logic         s02_axis_tvalid, s02_axis_tready, s02_axis_tlast;
  logic [W-1:0] s02_axis_tdata;
  logic         m01_axis_tvalid, m01_axis_tready, m01_axis_tlast;
  logic [W-1:0] m01_axis_tdata;
  logic         m02_axis_tvalid, m02_axis_tready, m02_axis_tlast;
  logic [W-1:0] m02_axis_tdata;
`ifdef STREAMMULT_SCHED_CNT_EN
  logic [31:0]  pkt_cnt0, pkt_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] d0[8];
  logic [W-1:0] d1[8];
  logic [32:0]  exp0[$];
  logic [32:0]  exp1[$];
  logic [32:0]  res0_log[$];
  int           res_dst[$];
  int           grant_log[$];
  int           gap_log[$];
  int           acc_beats[2];
  logic         abort_tx;
  logic [32:0]  mq[$];
  logic         mflush;
  logic         in_pkt;
  int           idle_run;
  int           cnt0, cnt1;

  streammult_sched #(.C_AXIS_TDATA_WIDTH(W), .C_ID_FIFO_DEPTH(4)) dut (
    .axis_aclk(axis_aclk), .axis_areset(axis_areset),
`ifdef STREAMMULT_SCHED_CNT_EN
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
`endif
    .s00_axis_tvalid(s00_axis_tvalid), .s00_axis_tready(s00_axis_tready),
    .s00_axis_tdata(s00_axis_tdata), .s00_axis_tlast(s00_axis_tlast),
    .s01_axis_tvalid(s01_axis_tvalid), .s01_axis_tready(s01_axis_tready),
    .s01_axis_tdata(s01_axis_tdata), .s01_axis_tlast(s01_axis_tlast),
    .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tready(m00_axis_tready),
    .m00_axis_tdata(m00_axis_tdata), .m00_axis_tlast(m00_axis_tlast),
    .s02_axis_tvalid(s02_axis_tvalid), .s02_axis_tready(s02_axis_tready),
    .s02_axis_tdata(s02_axis_tdata), .s02_axis_tlast(s02_axis_tlast),
    .m01_axis_tvalid(m01_axis_tvalid), .m01_axis_tready(m01_axis_tready),
    .m01_axis_tdata(m01_axis_tdata), .m01_axis_tlast(m01_axis_tlast),
    .m02_axis_tvalid(m02_axis_tvalid), .m02_axis_tready(m02_axis_tready),
    .m02_axis_tdata(m02_axis_tdata), .m02_axis_tlast(m02_axis_tlast)
  );

  initial axis_aclk = 1'b0;
  always #5 axis_aclk = ~axis_aclk;

  function automatic logic [W-1:0] mul(input logic [W-1:0] d);
    logic signed [15:0] a, b;
    logic signed [31:0] p;
    a = d[31:16];
    b = d[15:0];
    p = a * b;
    return p;
  endfunction

  function automatic logic [5:0] ctl_outs();
    return {m00_axis_tvalid, s00_axis_tready, s01_axis_tready,
            s02_axis_tready, m01_axis_tvalid, m02_axis_tvalid};
  endfunction

  // Multiplier model: accepts beats into an unbounded queue, presents the head on s02.
  logic         m_in_f, m_out_f, m_lin;
  logic [W-1:0] m_din;
  initial begin
    s02_axis_tvalid = 1'b0;
    s02_axis_tdata  = '0;
    s02_axis_tlast  = 1'b0;
    forever begin
      @(negedge axis_aclk);
      m_in_f  = m00_axis_tvalid && m00_axis_tready;
      m_out_f = s02_axis_tvalid && s02_axis_tready;
      m_din   = m00_axis_tdata;
      m_lin   = m00_axis_tlast;
      @(posedge axis_aclk);
      #1;
      if (m_out_f && mq.size() > 0) void'(mq.pop_front());
      if (m_in_f) mq.push_back({m_lin, mul(m_din)});
      if (mflush) mq.delete();
      if (mq.size() > 0) begin
        s02_axis_tvalid = 1'b1;
        {s02_axis_tlast, s02_axis_tdata} = mq[0];
      end else begin
        s02_axis_tvalid = 1'b0;
      end
    end
  end

  // Result scoreboard and routing log.
  logic [32:0] mon_e;
  initial begin
    cnt0 = 0;
    cnt1 = 0;
    forever begin
      @(negedge axis_aclk);
      if (axis_areset) begin
        cnt0 = 0;
        cnt1 = 0;
      end
      if (m01_axis_tvalid && m02_axis_tvalid) begin
        bad++;
        $display("FAIL route_onehot: m01_tvalid=1 m02_tvalid=1, required at most one");
      end
      if (m01_axis_tvalid && m01_axis_tready) begin
        total++;
        if (exp0.size() == 0) begin
          bad++;
          $display("FAIL m01_unexpected: got %h, required no beat", m01_axis_tdata);
        end else begin
          mon_e = exp0.pop_front();
          if ({m01_axis_tlast, m01_axis_tdata} !== mon_e) begin
            bad++;
            $display("FAIL m01_beat: got %h, required %h", {m01_axis_tlast, m01_axis_tdata}, mon_e);
          end
        end
        res0_log.push_back({m01_axis_tlast, m01_axis_tdata});
        if (m01_axis_tlast) begin
          res_dst.push_back(0);
          cnt0++;
        end
      end
      if (m02_axis_tvalid && m02_axis_tready) begin
        total++;
        if (exp1.size() == 0) begin
          bad++;
          $display("FAIL m02_unexpected: got %h, required no beat", m02_axis_tdata);
        end else begin
          mon_e = exp1.pop_front();
          if ({m02_axis_tlast, m02_axis_tdata} !== mon_e) begin
            bad++;
            $display("FAIL m02_beat: got %h, required %h", {m02_axis_tlast, m02_axis_tdata}, mon_e);
          end
        end
        if (m02_axis_tlast) begin
          res_dst.push_back(1);
          cnt1++;
        end
      end
    end
  end

  // Grant log: source of each packet on m00 and idle cycles preceding it.
  initial begin
    in_pkt   = 1'b0;
    idle_run = 0;
    forever begin
      @(negedge axis_aclk);
      if (axis_areset) in_pkt = 1'b0;
      if (m00_axis_tvalid && m00_axis_tready) begin
        if (!in_pkt) gap_log.push_back(idle_run);
        in_pkt   = 1'b1;
        idle_run = 0;
        if (m00_axis_tlast) begin
          grant_log.push_back(s01_axis_tready ? 1 : 0);
          in_pkt = 1'b0;
        end
      end else if (!m00_axis_tvalid) begin
        idle_run++;
      end
    end
  end

  task automatic drop(input int req);
    if (req == 1) begin
      s01_axis_tvalid = 1'b0;
      s01_axis_tlast  = 1'b0;
    end else begin
      s00_axis_tvalid = 1'b0;
      s00_axis_tlast  = 1'b0;
    end
  endtask

  task automatic send_pkt(input int req, input int n);
    logic rdy;
    int   t;
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] d;
      logic         l;
      d = (req == 1) ? d1[i] : d0[i];
      l = (i == n - 1);
      if (req == 1) begin
        s01_axis_tvalid = 1'b1; s01_axis_tdata = d; s01_axis_tlast = l;
      end else begin
        s00_axis_tvalid = 1'b1; s00_axis_tdata = d; s00_axis_tlast = l;
      end
      t = 0;
      forever begin
        @(negedge axis_aclk);
        rdy = (req == 1) ? s01_axis_tready : s00_axis_tready;
        @(posedge axis_aclk);
        if (abort_tx) begin
          drop(req);
          return;
        end
        if (rdy) break;
        t++;
        if (t > TMO) begin
          total++;
          bad++;
          $display("FAIL send_timeout: req %0d beat %0d not accepted, required within %0d cycles", req, i, TMO);
          drop(req);
          return;
        end
      end
      if (req == 1) exp1.push_back({l, mul(d)});
      else          exp0.push_back({l, mul(d)});
      acc_beats[req]++;
      #1;
    end
    drop(req);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp0.size() != 0 || exp1.size() != 0 || mq.size() != 0) && t < 100) begin
      @(posedge axis_aclk);
      t++;
    end
    @(posedge axis_aclk);
    #1;
    total++;
    if (exp0.size() + exp1.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results outstanding, required 0", exp0.size() + exp1.size());
    end
  endtask

  task automatic test_reset();
    axis_areset = 1'b1;
    repeat (2) @(posedge axis_aclk);
    #1;
    total++;
    if (ctl_outs() !== 6'b0) begin
      bad++;
      $display("FAIL reset_hold: ctl=%b, required 000000", ctl_outs());
    end
    @(posedge axis_aclk);
    #2;
    axis_areset = 1'b0;
    @(negedge axis_aclk);
    total++;
    if (ctl_outs() !== 6'b0) begin
      bad++;
      $display("FAIL reset_first: ctl=%b, required 000000", ctl_outs());
    end
    @(posedge axis_aclk);
    #1;
  endtask

  task automatic test_single();
    logic [32:0] ec[3];
    int b, m02_seen;
    ec = '{33'h0_00000006, 33'h0_FFFFFFFC, 33'h1_3FFF0001};
    d0[0] = 32'h00020003; d0[1] = 32'h0004FFFF; d0[2] = 32'h7FFF7FFF;
    b = res0_log.size();
    m02_seen = 0;
    fork
      send_pkt(0, 3);
      begin
        repeat (30) begin
          @(negedge axis_aclk);
          if (m02_axis_tvalid) m02_seen++;
        end
      end
    join
    total++;
    if (res0_log.size() - b != 3) begin
      bad++;
      $display("FAIL single_count: got %0d beats on m01, required 3", res0_log.size() - b);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (res0_log[b + i] !== ec[i]) begin
          bad++;
          $display("FAIL single_beat%0d: got %h, required %h", i, res0_log[b + i], ec[i]);
        end
      end
    end
    total++;
    if (m02_seen != 0) begin
      bad++;
      $display("FAIL single_m02: m02_tvalid high %0d cycles, required 0", m02_seen);
    end
    drain();
  endtask

  task automatic test_round_robin();
    int gb, gpb, rb;
    int eg[4];
    eg = '{0, 1, 0, 1};
    gb = grant_log.size(); gpb = gap_log.size(); rb = res_dst.size();
    d0[0] = 32'h00030004; d0[1] = 32'hFFFE0005;
    d1[0] = 32'h00070008; d1[1] = 32'h0010FFF0;
    axis_areset = 1'b1;
    @(posedge axis_aclk);
    #1;
    fork
      begin send_pkt(0, 2); send_pkt(0, 2); end
      begin send_pkt(1, 2); send_pkt(1, 2); end
      begin
        #1;
        total++;
        if (ctl_outs() !== 6'b0) begin
          bad++;
          $display("FAIL rr_reset_hold: ctl=%b, required 000000", ctl_outs());
        end
        @(posedge axis_aclk);
        #2;
        axis_areset = 1'b0;
        @(negedge axis_aclk);
        total++;
        if (ctl_outs() !== 6'b0) begin
          bad++;
          $display("FAIL rr_first_cycle: ctl=%b, required 000000", ctl_outs());
        end
      end
    join
    drain();
    total++;
    if (grant_log.size() - gb != 4 || gap_log.size() - gpb != 4 || res_dst.size() - rb != 4) begin
      bad++;
      $display("FAIL rr_counts: grants=%0d gaps=%0d results=%0d, required 4/4/4",
               grant_log.size() - gb, gap_log.size() - gpb, res_dst.size() - rb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (grant_log[gb + i] !== eg[i] || res_dst[rb + i] !== eg[i]) begin
          bad++;
          $display("FAIL rr_order%0d: grant=%0d result=%0d, required %0d", i,
                   grant_log[gb + i], res_dst[rb + i], eg[i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        total++;
        if (gap_log[gpb + i] !== 1) begin
          bad++;
          $display("FAIL rr_bubble%0d: idle cycles=%0d, required 1", i, gap_log[gpb + i]);
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    int gb, rb, blocked, t;
    gb = grant_log.size(); rb = res_dst.size();
    m02_axis_tready = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          d1[0] = 32'h00030000 | k;
          send_pkt(1, 1);
        end
      end
      begin
        repeat (20) @(posedge axis_aclk);
        @(negedge axis_aclk);
        total++;
        if (grant_log.size() - gb != 4) begin
          bad++;
          $display("FAIL full_grants: got %0d grants, required 4", grant_log.size() - gb);
        end
        blocked = 0;
        repeat (5) begin
          @(negedge axis_aclk);
          if (s01_axis_tready !== 1'b0) blocked++;
        end
        total++;
        if (blocked != 0) begin
          bad++;
          $display("FAIL full_block: s01_tready high %0d cycles, required 0", blocked);
        end
        @(posedge axis_aclk);
        #1;
        m02_axis_tready = 1'b1;
        t = 0;
        while (grant_log.size() - gb < 5 && t < 50) begin
          @(negedge axis_aclk);
          t++;
        end
        total++;
        if (grant_log.size() - gb != 5) begin
          bad++;
          $display("FAIL full_fifth: got %0d grants, required 5", grant_log.size() - gb);
        end
        total++;
        if (res_dst.size() - rb < 1) begin
          bad++;
          $display("FAIL full_pop_first: got %0d results before fifth grant, required >=1", res_dst.size() - rb);
        end
      end
    join
    drain();
  endtask

  task automatic test_backpressure();
    int gb, rb, viol, seen;
    gb = grant_log.size(); rb = res_dst.size();
    d1[0] = 32'h00020005; d1[1] = 32'hFFFF0007; d1[2] = 32'h01000100; d1[3] = 32'h80000002;
    fork
      send_pkt(1, 4);
      begin
        for (int k = 0; k < 12; k++) begin
          m00_axis_tready = (k % 2 == 0);
          @(posedge axis_aclk);
          #1;
        end
        m00_axis_tready = 1'b1;
      end
      begin
        viol = 0; seen = 0;
        for (int k = 0; k < 40 && grant_log.size() == gb; k++) begin
          @(negedge axis_aclk);
          #1;
          if (in_pkt) begin
            seen++;
            if (!(m00_axis_tvalid === 1'b1 && s01_axis_tready === m00_axis_tready && s00_axis_tready === 1'b0))
              viol++;
          end
        end
        total++;
        if (viol != 0 || seen < 3) begin
          bad++;
          $display("FAIL bp_hold_grant1: violations=%0d cycles=%0d, required 0 and >=3", viol, seen);
        end
      end
    join
    drain();
    total++;
    if (res_dst.size() - rb != 1 || res_dst[res_dst.size() - 1] !== 1) begin
      bad++;
      $display("FAIL bp_result: got %0d packets, required 1 on m02", res_dst.size() - rb);
    end
  endtask

  task automatic test_result_stall();
    int rb, t, stall_bad;
    logic [W-1:0] hold;
    rb = res_dst.size();
    d1[0] = 32'h00030003; d1[1] = 32'h0005FFFE; d0[0] = 32'h00060007;
    m02_axis_tready = 1'b0;
    fork
      begin send_pkt(1, 2); send_pkt(0, 1); end
      begin
        t = 0;
        do begin
          @(negedge axis_aclk);
          t++;
        end while (!s02_axis_tvalid && t < 50);
        hold = m02_axis_tdata;
        stall_bad = 0;
        repeat (5) begin
          @(negedge axis_aclk);
          if (s02_axis_tready !== 1'b0 || m02_axis_tvalid !== 1'b1 ||
              m02_axis_tdata !== hold || m01_axis_tvalid !== 1'b0) stall_bad++;
        end
        total++;
        if (stall_bad != 0) begin
          bad++;
          $display("FAIL stall_hold: %0d bad cycles, required 0", stall_bad);
        end
        total++;
        if (m02_axis_tdata !== 32'd9) begin
          bad++;
          $display("FAIL stall_data: got %h, required 00000009", m02_axis_tdata);
        end
        @(posedge axis_aclk);
        #1;
        m02_axis_tready = 1'b1;
      end
    join
    drain();
    total++;
    if (res_dst.size() - rb != 2 || res_dst[rb] !== 1 || res_dst[rb + 1] !== 0) begin
      bad++;
      $display("FAIL stall_route: got %0d packets, required m02 then m01", res_dst.size() - rb);
    end
  endtask

  task automatic test_reset_midpkt();
    int ab, t, gb, zbad;
    ab = acc_beats[0];
    d0[0] = 32'h00010002; d0[1] = 32'h00030004; d0[2] = 32'h00050006; d0[3] = 32'h00070008;
    fork
      send_pkt(0, 4);
      begin
        t = 0;
        do begin
          @(posedge axis_aclk);
          #3;
          t++;
        end while (acc_beats[0] == ab && t < 50);
        axis_areset = 1'b1;
        abort_tx = 1'b1;
        #1;
        total++;
        if (ctl_outs() !== 6'b0) begin
          bad++;
          $display("FAIL midrst_outs: ctl=%b, required 000000", ctl_outs());
        end
      end
    join
    repeat (2) @(posedge axis_aclk);
    #1;
    abort_tx = 1'b0;
    @(posedge axis_aclk);
    #2;
    axis_areset = 1'b0;
    zbad = 0;
    repeat (3) begin
      @(negedge axis_aclk);
      if (ctl_outs() !== 6'b0) zbad++;
    end
    total++;
    if (zbad != 0) begin
      bad++;
      $display("FAIL midrst_empty: %0d cycles with active handshake, required 0", zbad);
    end
    @(posedge axis_aclk);
    #3;
    mflush = 1'b1;
    repeat (2) @(posedge axis_aclk);
    #3;
    mflush = 1'b0;
    exp0.delete();
    @(posedge axis_aclk);
    #1;
    gb = grant_log.size();
    d0[0] = 32'h00090009; d1[0] = 32'h000A000B;
    fork
      send_pkt(0, 1);
      send_pkt(1, 1);
    join
    drain();
    total++;
    if (grant_log.size() - gb != 2 || grant_log[gb] !== 0 || grant_log[gb + 1] !== 1) begin
      bad++;
      $display("FAIL midrst_tie: got %0d grants first=%0d, required s00 then s01",
               grant_log.size() - gb, (grant_log.size() > gb) ? grant_log[gb] : -1);
    end
    gb = grant_log.size();
    send_pkt(1, 1);
    drain();
    total++;
    if (grant_log.size() - gb != 1 || grant_log[gb] !== 1) begin
      bad++;
      $display("FAIL midrst_solo: got %0d grants, required one from s01", grant_log.size() - gb);
    end
  endtask

  initial begin
    axis_areset     = 1'b1;
    abort_tx        = 1'b0;
    mflush          = 1'b0;
    acc_beats[0]    = 0;
    acc_beats[1]    = 0;
    s00_axis_tvalid = 1'b0; s00_axis_tdata = '0; s00_axis_tlast = 1'b0;
    s01_axis_tvalid = 1'b0; s01_axis_tdata = '0; s01_axis_tlast = 1'b0;
    m00_axis_tready = 1'b1;
    m01_axis_tready = 1'b1;
    m02_axis_tready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_fifo_full();
    test_backpressure();
    test_result_stall();
    test_reset_midpkt();
`ifdef STREAMMULT_SCHED_CNT_EN
    total++;
    if (pkt_cnt0 !== cnt0 || pkt_cnt1 !== cnt1) begin
      bad++;
      $display("FAIL pkt_cnt: got %0d/%0d, required %0d/%0d", pkt_cnt0, pkt_cnt1, cnt0, cnt1);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
